// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Write-posting store FIFO between the MEM stage and data memory,
//               with store-to-load forwarding when STORE_BUF_FWD_EN is defined
//               (otherwise conflicting loads are stalled via ld_stall).
// Revision    : 1.0
// ============================================================================
module store_buffer #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [WORD_LEN-1:0]        st_addr,
    input  logic [WORD_LEN-1:0]        st_data,
    input  logic                       ld_valid,
    input  logic [WORD_LEN-1:0]        ld_addr,
    input  logic                       drain_hold,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       fwd_hit,
    output logic [WORD_LEN-1:0]        fwd_data,
    output logic                       ld_stall,
    output logic                       mem_writeEn,
    output logic [WORD_LEN-1:0]        mem_address,
    output logic [WORD_LEN-1:0]        mem_dataIn
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [WORD_LEN-1:0] c_LOW_LIMIT = WORD_LEN'(1024);
    // Bit 10 and the byte offset are ignored when matching, as memory does.
    localparam logic [WORD_LEN-1:0] c_TAG_MASK  = ~(WORD_LEN'(32'h0000_0403));

    logic [WORD_LEN-1:0] r_addr [DEPTH];
    logic [WORD_LEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [DEPTH-1:0]    w_push_mask;
    logic [DEPTH-1:0]    w_pop_mask;
    logic                w_hit;
    logic [c_PTR_W-1:0]  w_idx;
`ifdef STORE_BUF_FWD_EN
    logic [WORD_LEN-1:0] w_hit_data;
`endif

    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = st_valid && !w_full;
    assign w_pop       = !w_empty && !drain_hold;
    assign w_push_mask = w_push ? (DEPTH'(1) << r_wr_ptr) : '0;
    assign w_pop_mask  = w_pop  ? (DEPTH'(1) << r_rd_ptr) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_valid <= (r_valid & ~w_pop_mask) | w_push_mask;
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Entry payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_hit = 1'b0;
        w_idx = r_rd_ptr;
`ifdef STORE_BUF_FWD_EN
        w_hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_PTR_W'(i);
            if (r_valid[w_idx] && (((r_addr[w_idx] ^ ld_addr) & c_TAG_MASK) == '0)) begin
                w_hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
                w_hit_data = r_data[w_idx];
`endif
            end
        end
        if (!ld_valid || (ld_addr < c_LOW_LIMIT)) begin
            w_hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
            w_hit_data = '0;
`endif
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign fwd_hit  = w_hit;
    assign fwd_data = w_hit_data;
    assign ld_stall = 1'b0;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign ld_stall = w_hit;
`endif

    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign mem_writeEn = w_pop;
    assign mem_address = w_empty ? '0 : r_addr[r_rd_ptr];
    assign mem_dataIn  = w_empty ? '0 : r_data[r_rd_ptr];

endmodule
`default_nettype wire
